// File: rtl/smart_gate_controller_p_if.sv
// Lane-side bundle for the smart gate controller: sensor/payment inputs, barrier commands,
// traffic lights and lot counters.
interface smart_gate_controller_p_if #(
   parameter int unsigned CNT_W = 8
);
   logic             car_i;
   logic             pay_ok_i;
   logic             clear_i;
   logic             exit_i;
   logic             cnt_reset_i;
   logic             gate_open_o;
   logic             gate_close_o;
   logic             red_o;
   logic             yellow_o;
   logic             green_o;
   logic             abort_o;
   logic             full_o;
   logic [CNT_W-1:0] car_count_o;
   logic [CNT_W-1:0] occupancy_o;

   modport slave (
      input  car_i, pay_ok_i, clear_i, exit_i, cnt_reset_i,
      output gate_open_o, gate_close_o, red_o, yellow_o, green_o, abort_o, full_o,
      output car_count_o, occupancy_o
   );

   modport master (
      output car_i, pay_ok_i, clear_i, exit_i, cnt_reset_i,
      input  gate_open_o, gate_close_o, red_o, yellow_o, green_o, abort_o, full_o,
      input  car_count_o, occupancy_o
   );
endinterface

// File: rtl/smart_gate_controller_p.sv
// Single-lane barrier controller with programmable phase lengths, clear-wait abort and lot
// occupancy tracking. All state advances on the falling edge of clk_i.
module smart_gate_controller_p #(
   parameter int unsigned CNT_W         = 8,
   parameter int unsigned CAPACITY      = 200,
   parameter int unsigned PRE_OPEN_CYC  = 2,
   parameter int unsigned PASS_CYC      = 3,
   parameter int unsigned CLEAR_TIMEOUT = 16,
   parameter int unsigned TMR_W         = 8
) (
   input logic                      clk_i,
   input logic                      reset_i,
   smart_gate_controller_p_if.slave gate_if
);

   typedef enum logic [2:0] {
      StIdle, StPreOpen, StWaitClear, StOpenPulse, StPass, StPreClose, StClose, StAbort
   } state_e;

   localparam logic [CNT_W-1:0] CapVal      = CNT_W'(CAPACITY);
   localparam logic [CNT_W-1:0] CntMax      = '1;
   localparam logic [TMR_W-1:0] TmrMax      = '1;
   localparam logic [TMR_W-1:0] PreOpenLast = TMR_W'(PRE_OPEN_CYC - 1);
   localparam logic [TMR_W-1:0] PassLast    = TMR_W'(PASS_CYC - 1);
   localparam logic [TMR_W-1:0] ClearLast   = TMR_W'(CLEAR_TIMEOUT - 1);

   state_e           r_state_q, w_state_d;
   logic [TMR_W-1:0] r_tmr_q, w_tmr_d;
   logic [CNT_W-1:0] r_count_q, w_count_d;
   logic [CNT_W-1:0] r_occ_q, w_occ_d;
   logic             w_full;
   logic             w_admit;

   assign w_full  = (r_occ_q >= CapVal);
   assign w_admit = (r_state_q == StOpenPulse);

   always_comb begin
      w_state_d = r_state_q;
      case (r_state_q)
         StIdle:      if (gate_if.car_i && gate_if.pay_ok_i && !w_full) w_state_d = StPreOpen;
         StPreOpen:   if (r_tmr_q == PreOpenLast) w_state_d = StWaitClear;
         StWaitClear: begin
            // clear_i takes precedence over the timeout on the final cycle
            if (gate_if.clear_i)             w_state_d = StOpenPulse;
            else if (r_tmr_q == ClearLast)   w_state_d = StAbort;
         end
         StOpenPulse: w_state_d = StPass;
         StPass:      if (r_tmr_q == PassLast) w_state_d = StPreClose;
         StPreClose:  w_state_d = StClose;
         StClose:     w_state_d = StIdle;
         StAbort:     w_state_d = StIdle;
         default:     w_state_d = StIdle;
      endcase
   end

   always_comb begin
      w_tmr_d = r_tmr_q;
      if (w_state_d != r_state_q) w_tmr_d = '0;
      else if (r_tmr_q != TmrMax) w_tmr_d = r_tmr_q + TMR_W'(1);
   end

   always_comb begin
      w_count_d = r_count_q;
      if (gate_if.cnt_reset_i)                   w_count_d = '0;
      else if (w_admit && (r_count_q != CntMax)) w_count_d = r_count_q + CNT_W'(1);
   end

   // Simultaneous entry and exit cancel; the entry side still clamps at capacity.
   always_comb begin
      w_occ_d = r_occ_q;
      if (w_admit && !gate_if.exit_i) begin
         if (r_occ_q < CapVal) w_occ_d = r_occ_q + CNT_W'(1);
      end else if (!w_admit && gate_if.exit_i && (r_occ_q != '0)) begin
         w_occ_d = r_occ_q - CNT_W'(1);
      end
   end

   always_ff @(negedge clk_i) begin
      if (reset_i) begin
         r_state_q <= StIdle;
         r_tmr_q   <= '0;
         r_count_q <= '0;
         r_occ_q   <= '0;
      end else begin
         r_state_q <= w_state_d;
         r_tmr_q   <= w_tmr_d;
         r_count_q <= w_count_d;
         r_occ_q   <= w_occ_d;
      end
   end

   always_comb begin
      gate_if.red_o        = 1'b0;
      gate_if.yellow_o     = 1'b0;
      gate_if.green_o      = 1'b0;
      gate_if.gate_open_o  = 1'b0;
      gate_if.gate_close_o = 1'b0;
      gate_if.abort_o      = 1'b0;
      case (r_state_q)
         StIdle:      gate_if.red_o = 1'b1;
         StPreOpen:   gate_if.yellow_o = 1'b1;
         StWaitClear: gate_if.yellow_o = 1'b1;
         StOpenPulse: begin
            gate_if.green_o     = 1'b1;
            gate_if.gate_open_o = 1'b1;
         end
         StPass:      gate_if.green_o = 1'b1;
         StPreClose:  gate_if.yellow_o = 1'b1;
         StClose: begin
            gate_if.red_o        = 1'b1;
            gate_if.gate_close_o = 1'b1;
         end
         StAbort: begin
            gate_if.red_o   = 1'b1;
            gate_if.abort_o = 1'b1;
         end
         default:     gate_if.red_o = 1'b1;
      endcase
   end

   assign gate_if.full_o      = w_full;
   assign gate_if.car_count_o = r_count_q;
   assign gate_if.occupancy_o = r_occ_q;

endmodule

// File: tb/tb_smart_gate_controller_p.sv
// Directed bench: a default-parameter lane (A) and a small lane with CNT_W=2, CAPACITY=2 (B).
// Expected light sequences are queued per transaction and popped cycle by cycle.
module tb_smart_gate_controller_p;

   localparam int CLR_TO = 16;

   // Light vector: {red, yellow, green, gate_open, gate_close, abort}
   localparam logic [5:0] L_RED   = 6'b100000;
   localparam logic [5:0] L_YEL   = 6'b010000;
   localparam logic [5:0] L_GRN   = 6'b001000;
   localparam logic [5:0] L_OPEN  = 6'b001100;
   localparam logic [5:0] L_CLOSE = 6'b100010;
   localparam logic [5:0] L_ABORT = 6'b100001;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;
   logic [5:0] exp_q[$];

   always #5 clk = ~clk;

   smart_gate_controller_p_if #(.CNT_W(8)) ifa ();
   smart_gate_controller_p_if #(.CNT_W(2)) ifb ();

   smart_gate_controller_p #(.CNT_W(8)) dut_a (
      .clk_i   (clk),
      .reset_i (rst),
      .gate_if (ifa)
   );

   smart_gate_controller_p #(.CNT_W(2), .CAPACITY(2)) dut_b (
      .clk_i   (clk),
      .reset_i (rst),
      .gate_if (ifb)
   );

   // DUT updates on negedge; sampling and driving happen on posedge.
   task automatic tick();
      @(posedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit sel, input bit car, input bit pay, input bit clr,
                        input bit ex, input bit cr);
      if (sel) begin
         ifb.car_i = car; ifb.pay_ok_i = pay; ifb.clear_i = clr;
         ifb.exit_i = ex; ifb.cnt_reset_i = cr;
      end else begin
         ifa.car_i = car; ifa.pay_ok_i = pay; ifa.clear_i = clr;
         ifa.exit_i = ex; ifa.cnt_reset_i = cr;
      end
   endtask

   function automatic logic [5:0] lights(input bit sel);
      if (sel) return {ifb.red_o, ifb.yellow_o, ifb.green_o,
                       ifb.gate_open_o, ifb.gate_close_o, ifb.abort_o};
      return {ifa.red_o, ifa.yellow_o, ifa.green_o,
              ifa.gate_open_o, ifa.gate_close_o, ifa.abort_o};
   endfunction

   function automatic logic [31:0] count(input bit sel);
      return sel ? 32'(ifb.car_count_o) : 32'(ifa.car_count_o);
   endfunction

   function automatic logic [31:0] occ(input bit sel);
      return sel ? 32'(ifb.occupancy_o) : 32'(ifa.occupancy_o);
   endfunction

   function automatic logic [31:0] full(input bit sel);
      return sel ? 32'(ifb.full_o) : 32'(ifa.full_o);
   endfunction

   // One paid car; clear_at = WAIT_CLEAR cycle on which clear_i rises (0 = never -> abort).
   task automatic run_car(input bit sel, input int clear_at, input bit ex_open,
                          input bit cr_open, input string tag);
      int n_wait;
      int n;
      logic [5:0] exp;
      n_wait = (clear_at == 0) ? CLR_TO : clear_at;
      exp_q.push_back(L_YEL);
      exp_q.push_back(L_YEL);
      repeat (n_wait) exp_q.push_back(L_YEL);
      if (clear_at != 0) begin
         exp_q.push_back(L_OPEN);
         repeat (3) exp_q.push_back(L_GRN);
         exp_q.push_back(L_YEL);
         exp_q.push_back(L_CLOSE);
      end else begin
         exp_q.push_back(L_ABORT);
      end
      exp_q.push_back(L_RED);
      n = exp_q.size();
      drive(sel, 1, 1, 0, 0, 0);
      for (int i = 0; i < n; i++) begin
         tick();
         exp = exp_q.pop_front();
         chk($sformatf("%s.light%0d", tag, i), 32'(lights(sel)), 32'(exp));
         if (i == 0) drive(sel, 0, 0, 0, 0, 0);
         if (clear_at != 0 && i == 1 + clear_at) drive(sel, 0, 0, 1, 0, 0);
         if (clear_at != 0 && i == 2 + clear_at) drive(sel, 0, 0, 0, ex_open, cr_open);
         if (clear_at != 0 && i == 3 + clear_at) drive(sel, 0, 0, 0, 0, 0);
      end
   endtask

   task automatic exit_pulse(input bit sel);
      drive(sel, 0, 0, 0, 1, 0);
      tick();
      drive(sel, 0, 0, 0, 0, 0);
   endtask

   initial begin
      drive(0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0);
      rst = 1'b1;
      @(posedge clk);
      tick();
      tick();
      chk("rst.a.lights", 32'(lights(0)), 32'(L_RED));
      chk("rst.a.count", count(0), 0);
      chk("rst.a.occ", occ(0), 0);
      chk("rst.a.full", full(0), 0);
      chk("rst.b.lights", 32'(lights(1)), 32'(L_RED));
      chk("rst.b.occ", occ(1), 0);
      rst = 1'b0;

      // Lane A: normal pass, abort, clear on the last wait cycle, exit during open pulse
      run_car(0, 1, 0, 0, "a.pass");
      chk("a.pass.count", count(0), 1);
      chk("a.pass.occ", occ(0), 1);
      run_car(0, 0, 0, 0, "a.abort");
      chk("a.abort.count", count(0), 1);
      chk("a.abort.occ", occ(0), 1);
      run_car(0, CLR_TO, 0, 0, "a.lastclr");
      chk("a.lastclr.count", count(0), 2);
      chk("a.lastclr.occ", occ(0), 2);
      chk("a.lastclr.full", full(0), 0);
      run_car(0, 1, 1, 0, "a.exitopen");
      chk("a.exitopen.count", count(0), 3);
      chk("a.exitopen.occ", occ(0), 2);
      exit_pulse(0);
      chk("a.exit1.occ", occ(0), 1);
      exit_pulse(0);
      chk("a.exit2.occ", occ(0), 0);
      exit_pulse(0);
      chk("a.exit0.occ", occ(0), 0);
      chk("a.exit0.count", count(0), 3);

      // Lane B: capacity limit, refusal, saturation, count reset during open pulse
      run_car(1, 1, 0, 0, "b.car1");
      chk("b.car1.occ", occ(1), 1);
      chk("b.car1.full", full(1), 0);
      run_car(1, 1, 0, 0, "b.car2");
      chk("b.car2.occ", occ(1), 2);
      chk("b.car2.full", full(1), 1);
      chk("b.car2.count", count(1), 2);
      drive(1, 1, 1, 0, 0, 0);
      tick();
      chk("b.refuse.l0", 32'(lights(1)), 32'(L_RED));
      tick();
      chk("b.refuse.l1", 32'(lights(1)), 32'(L_RED));
      drive(1, 0, 0, 0, 0, 0);
      exit_pulse(1);
      chk("b.exit.occ", occ(1), 1);
      chk("b.exit.full", full(1), 0);
      run_car(1, 1, 0, 0, "b.car3");
      chk("b.car3.count", count(1), 3);
      chk("b.car3.occ", occ(1), 2);
      exit_pulse(1);
      run_car(1, 1, 0, 0, "b.car4");
      chk("b.car4.sat", count(1), 3);
      chk("b.car4.occ", occ(1), 2);
      exit_pulse(1);
      run_car(1, 1, 0, 1, "b.cntrst");
      chk("b.cntrst.count", count(1), 0);
      chk("b.cntrst.occ", occ(1), 2);

      // Lane A: reset while in PASS
      drive(0, 1, 1, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      tick();
      tick();
      drive(0, 0, 0, 1, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      tick();
      chk("a.midrst.pass", 32'(lights(0)), 32'(L_GRN));
      chk("a.midrst.occ_before", occ(0), 1);
      rst = 1'b1;
      tick();
      chk("a.midrst.lights", 32'(lights(0)), 32'(L_RED));
      chk("a.midrst.count", count(0), 0);
      chk("a.midrst.occ", occ(0), 0);
      chk("b.midrst.count", count(1), 0);
      rst = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
